// File: rtl/misr_pkg.sv
// Shared types, defaults and MISR step function for the signature capture block.
// Ports: none (package).
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_e;

  localparam int          MISR_MAX_W   = 32;
  localparam logic [7:0]  MISR_POLY_DF = 8'hB8;
  localparam logic [7:0]  MISR_SEED_DF = 8'h00;

  // One MISR step for any width w <= MISR_MAX_W; operands are zero-extended
  // and the result is truncated back to w bits by the caller.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] poly,
    input logic [MISR_MAX_W-1:0] data,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] m;
    logic [MISR_MAX_W-1:0] r;
    m = (w >= MISR_MAX_W) ? '1
      : ((MISR_MAX_W'(1) << w) - MISR_MAX_W'(1));
    r = {sig[MISR_MAX_W-2:0], ^(sig & poly & m)} ^ data;
    return r & m;
  endfunction

endpackage

// File: rtl/misr_signature_capture_if.sv
// Capture control/status bundle: master drives start/config/samples,
// slave (the capture block) returns busy/done/signature/count/match.
interface misr_signature_capture_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] sample_count;
  logic             match;

  modport master (
    output start, num_samples, expected, data_in, valid_in,
    input  busy, done, signature, sample_count, match
  );

  modport slave (
    input  start, num_samples, expected, data_in, valid_in,
    output busy, done, signature, sample_count, match
  );

endinterface

// File: rtl/misr_core.sv
// MISR signature register: load reseeds, en absorbs one data word.
// Ports: clk, rst, en, load, seed, data_in -> sig.
module misr_core
  import misr_pkg::*;
#(
  parameter int             WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(MISR_POLY_DF),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(MISR_SEED_DF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = WIDTH'(misr_next(MISR_MAX_W'(sig_q),
                               MISR_MAX_W'(POLY),
                               MISR_MAX_W'(data_in),
                               WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= SEED;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/misr_signature_capture.sv
// Signature capture: FSM, sample counter and golden compare around misr_core.
// Ports: clk, rst, bus (slave: start/num_samples/expected/data_in/valid_in in).
module misr_signature_capture
  import misr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY_DF),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(MISR_SEED_DF),
  parameter int               CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  misr_signature_capture_if.slave  bus
);

  misr_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             load;
  logic             en;
  logic [WIDTH-1:0] sig;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    load    = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          num_d   = bus.num_samples;
          exp_d   = bus.expected;
          state_d = (bus.num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.valid_in) begin
          en    = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          // Last sample and DONE entry share one edge.
          if (cnt_q == num_q - CNT_W'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
    end
  end

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .seed    (SEED),
    .data_in (bus.data_in),
    .sig     (sig)
  );

  assign bus.busy         = (state_q == RUN);
  assign bus.done         = (state_q == DONE);
  assign bus.signature    = sig;
  assign bus.sample_count = cnt_q;
  assign bus.match        = (state_q == DONE) && (sig == exp_q);

endmodule
